multiword_add_seq: RTL
======================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 Parameter N, default 8: slice width in bits, equal to the width of one adder pass.
REQ-002 Parameter W, default 4: number of slices per operand, so the operand width is N*W.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin one addition; sampled only in IDLE.
REQ-006 a  input  N*W  first operand; sampled on the accepted start edge.
REQ-007 b  input  N*W  second operand; sampled on the accepted start edge.
REQ-008 cin  input  1  carry-in to slice 0; sampled on the accepted start edge.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse marking sum/cout valid.
REQ-011 sum  output  N*W  result register.
REQ-012 cout  output  1  carry out of slice W-1.

Function
REQ-013 The module SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 IDLE -> RUN on start=1; on that edge capture a, b and cin, clear the slice index to 0 and clear sum.
REQ-015 In RUN, each edge SHALL add slice idx of a, b and the carry register, write the result to sum[idx*N +: N], load the carry register with the slice carry, and increment idx.
REQ-016 RUN -> DONE on the edge that processes slice W-1; cout takes the final carry on that edge.
REQ-017 DONE -> IDLE unconditionally after one cycle; done=1 only while in DONE.
REQ-018 Latency: with start sampled at edge 0, done SHALL be high in the cycle following edge W (edge 4 for W=4).
REQ-019 sum and cout SHALL hold their values from DONE until the next accepted start; intermediate sum values during RUN are not valid.
REQ-020 start while busy=1, including in DONE, SHALL be ignored with no effect on state or captured operands.
REQ-021 Changes to a, b or cin after capture SHALL NOT affect the result.
REQ-022 Arithmetic is unsigned modulo 2^(N*W); overflow is reported only through cout.

Reset
REQ-023 rst=1 SHALL force IDLE, idx=0, carry register=0, sum=0, cout=0, done=0 and busy=0, in any state including mid-RUN.
REQ-024 rst SHALL take priority over start on the same edge.

Configuration
REQ-025 When SUBTRACT_EN is defined, input sub (1 bit) SHALL be sampled with the operands; sub=1 computes a-b as a + ~b + 1, with the slice-0 carry forced to 1 and cin ignored; cout=1 means no borrow.
REQ-026 When SUBTRACT_EN is undefined, the sub port and its logic SHALL be absent and behaviour is add-only.

Structure
REQ-027 Package multiword_add_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default N and W constants.
REQ-028 The per-cycle slice add SHALL be performed by exactly one instance of the codebase's N-bit ripple-carry adder module (adder8bit), reused every RUN cycle.
REQ-029 The slice index SHALL be clog2(W) bits wide, with a minimum of 1 bit.

Verification
REQ-030 a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1; done high in the cycle following edge 4 after start.
REQ-031 a=0x12345678, b=0x11111111, cin=0 -> sum=0x23456789, cout=0; busy high for 5 cycles.
REQ-032 a=0, b=0, cin=1 -> sum=0x00000001, cout=0.
REQ-033 Second start pulsed mid-RUN with different operands -> ignored; first result delivered and done pulses once.
REQ-034 rst asserted in RUN after slice 1 -> next cycle IDLE with all outputs 0; a fresh start then completes correctly.
REQ-035 With SUBTRACT_EN defined: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0; a=7, b=5, sub=1 -> sum=0x00000002, cout=1.

Source files
------------

// File: rtl/multiword_add_pkg.sv
// Shared types and default sizing for the sequential multiword adder.
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N = 8;
  localparam int DEF_W = 4;

endpackage

// File: rtl/adder8bit.sv
// Combinational N-bit ripple-carry adder, one slice of the multiword adder.
module adder8bit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic c;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential N*W-bit adder that reuses one N-bit adder slice per cycle.
// Optional feature: define SUBTRACT_EN to add the 'sub' input (a-b mode).
import multiword_add_pkg::*;

module multiword_add_seq #(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
`ifdef SUBTRACT_EN
  input  logic           sub,
`endif
  input  logic           cin,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] sum,
  output logic           cout
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST = IW'(W - 1);

  state_t state, state_next;

  logic [N*W-1:0] a_q, b_q;
  logic [IW-1:0]  idx;
  logic           carry;
  logic [N-1:0]   a_slice, b_slice, b_in, slice_sum;
  logic           slice_cout;

  assign a_slice = a_q[int'(idx)*N +: N];
  assign b_slice = b_q[int'(idx)*N +: N];

`ifdef SUBTRACT_EN
  logic sub_q;
  // Subtraction inverts b; the +1 comes from the forced slice-0 carry.
  assign b_in = sub_q ? ~b_slice : b_slice;
`else
  assign b_in = b_slice;
`endif

  adder8bit #(.N(N)) u_slice (
    .a    (a_slice),
    .b    (b_in),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (idx == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Operands are captured once; only the registered copies feed the slice adder.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SUBTRACT_EN
      sub_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            idx <= '0;
            sum <= '0;
`ifdef SUBTRACT_EN
            sub_q <= sub;
            carry <= sub ? 1'b1 : cin;
`else
            carry <= cin;
`endif
          end
        end
        RUN: begin
          sum[int'(idx)*N +: N] <= slice_sum;
          carry <= slice_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST) cout <= slice_cout;
        end
        default: ;
      endcase
    end
  end

endmodule
